// File: rtl/ysyx_bus_sched.sv
// Single-outstanding arbiter from IFU/LSU onto an AXI-lite master port.
// LSU has priority over IFU, except that IFU wins once it has lost STARVE_MAX arbitrations in a row.
module ysyx_bus_sched #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  output logic        lsu_gnt,
  output logic        lsu_done,
  output logic [31:0] rdata,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        bus_err
);

  // state | meaning
  // IDLE  | arbitrate, grant in this cycle
  // IF_AR | IFU read address phase
  // IF_R  | IFU read data phase
  // LS_AR | LSU load address phase
  // LS_R  | LSU load data phase
  // LS_W  | LSU store address + data phases (independent handshakes)
  // LS_B  | LSU store response phase
  typedef enum logic [2:0] {IDLE, IF_AR, IF_R, LS_AR, LS_R, LS_W, LS_B} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state, state_nxt;
  logic [3:0]  starve_cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_done, w_done;
  logic        pick_ifu, pick_lsu;
  logic        r_fire, b_fire;

  // Gated by rst so grants stay low while reset is asserted.
  always_comb begin
    pick_ifu = 1'b0;
    pick_lsu = 1'b0;
    if (state == IDLE && rst) begin
      if (ifu_req && (!lsu_req || starve_cnt == STARVE_LIM)) pick_ifu = 1'b1;
      else if (lsu_req)                                       pick_lsu = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_ifu)      state_nxt = IF_AR;
        else if (pick_lsu) state_nxt = lsu_we ? LS_W : LS_AR;
      end
      IF_AR: if (m_arready) state_nxt = IF_R;
      IF_R:  if (m_rvalid)  state_nxt = IDLE;
      LS_AR: if (m_arready) state_nxt = LS_R;
      LS_R:  if (m_rvalid)  state_nxt = IDLE;
      LS_W:  if ((aw_done || m_awready) && (w_done || m_wready)) state_nxt = LS_B;
      LS_B:  if (m_bvalid)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ifu_gnt    = pick_ifu;
    lsu_gnt    = pick_lsu;
    m_arvalid  = (state == IF_AR) || (state == LS_AR);
    m_araddr   = m_arvalid ? addr_q : 32'h0;
    m_awvalid  = (state == LS_W) && !aw_done;
    m_awaddr   = m_awvalid ? addr_q : 32'h0;
    m_wvalid   = (state == LS_W) && !w_done;
    m_wdata    = m_wvalid ? wdata_q : 32'h0;
    m_wstrb    = m_wvalid ? wstrb_q : 4'h0;
    r_fire     = ((state == IF_R) || (state == LS_R)) && m_rvalid;
    b_fire     = (state == LS_B) && m_bvalid;
    ifu_rvalid = (state == IF_R) && m_rvalid;
    lsu_done   = ((state == LS_R) && m_rvalid) || b_fire;
    rdata      = r_fire ? m_rdata : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pick_ifu) begin
        addr_q     <= ifu_addr;
        starve_cnt <= 4'd0;
      end
      if (pick_lsu) begin
        addr_q  <= lsu_addr;
        wdata_q <= lsu_wdata;
        wstrb_q <= lsu_wstrb;
        if (ifu_req && starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
      end
      if (state == LS_W) begin
        if (m_awvalid && m_awready) aw_done <= 1'b1;
        if (m_wvalid && m_wready)   w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if ((r_fire && m_rresp != 2'b00) || (b_fire && m_bresp != 2'b00)) bus_err <= 1'b1;
    end
  end

endmodule
